// File: rtl/multiplier_sequencer.sv
// Sequencer for the registered multiplier wrapper: accepts operand pairs, drives the
// wrapper's write/read/reset enables in a fixed schedule and returns one result per op.
module multiplier_sequencer #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inValid,
    output logic           inReady,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           outValid,
    input  logic           outReady,
    output logic [2*N-1:0] result,
    output logic           resultOverflow,
    output logic           resultError,
    output logic [N-1:0]   opA,
    output logic [N-1:0]   opB,
    output logic           writeEnableA,
    output logic           writeEnableB,
    output logic           writeEnableOut,
    output logic           readEnableA,
    output logic           readEnableB,
    output logic           readEnableOut,
    output logic           resetA,
    output logic           resetB,
    output logic           resetOut,
    input  logic [2*N-1:0] productIn,
    input  logic           overflowIn,
    input  logic           accessErrorA,
    input  logic           accessErrorB,
    input  logic           accessErrorOut
);

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        IDLE    = 3'd1,
        LOAD    = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_e;

    // Enable bundle order: {weA, weB, weOut, reA, reB, reOut, rstA, rstB, rstOut}
    localparam logic [8:0] EN_NONE    = 9'b000_000_000;
    localparam logic [8:0] EN_CLEAR   = 9'b000_000_111;
    localparam logic [8:0] EN_LOAD    = 9'b110_000_000;
    localparam logic [8:0] EN_COMPUTE = 9'b001_110_000;
    localparam logic [8:0] EN_DRAIN   = 9'b000_001_000;

    state_e         state_q, state_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic [2*N-1:0] result_q, result_d;
    logic           ovf_q, ovf_d;
    logic           err_q, err_d;
    logic [8:0]     enables_q, enables_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           any_err_s;

    assign any_err_s = accessErrorA | accessErrorB | accessErrorOut;

    // Next-state, datapath capture and registered-output decode of the upcoming state.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        enables_d   = EN_NONE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            CLEAR: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (inValid) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                err_d   = err_q | any_err_s;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                err_d   = err_q | any_err_s;
                ovf_d   = overflowIn;
                state_d = DRAIN;
            end
            DRAIN: begin
                err_d    = err_q | any_err_s;
                result_d = productIn;
                state_d  = DONE;
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered.
        case (state_d)
            CLEAR:   enables_d   = EN_CLEAR;
            IDLE:    in_ready_d  = 1'b1;
            LOAD:    enables_d   = EN_LOAD;
            COMPUTE: enables_d   = EN_COMPUTE;
            DRAIN:   enables_d   = EN_DRAIN;
            DONE:    out_valid_d = 1'b1;
            default: enables_d   = EN_CLEAR;
        endcase
    end

    // State and output registers; reset parks in CLEAR with the wrapper resets asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            enables_q   <= EN_CLEAR;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            enables_q   <= enables_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign inReady        = in_ready_q;
    assign outValid       = out_valid_q;
    assign result         = result_q;
    assign resultOverflow = ovf_q;
    assign resultError    = err_q;
    assign opA            = op_a_q;
    assign opB            = op_b_q;

    assign {writeEnableA, writeEnableB, writeEnableOut,
            readEnableA, readEnableB, readEnableOut,
            resetA, resetB, resetOut} = enables_q;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Directed bench for multiplier_sequencer with a small behavioural model of the
// registered multiplier wrapper feeding productIn.
module tb_multiplier_sequencer;

    localparam int N = 32;

    localparam logic [8:0] EN_NONE    = 9'b000_000_000;
    localparam logic [8:0] EN_CLEAR   = 9'b000_000_111;
    localparam logic [8:0] EN_LOAD    = 9'b110_000_000;
    localparam logic [8:0] EN_COMPUTE = 9'b001_110_000;
    localparam logic [8:0] EN_DRAIN   = 9'b000_001_000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           inValid = 1'b0;
    logic           inReady;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           outValid;
    logic           outReady = 1'b0;
    logic [2*N-1:0] result;
    logic           resultOverflow;
    logic           resultError;
    logic [N-1:0]   opA;
    logic [N-1:0]   opB;
    logic           writeEnableA, writeEnableB, writeEnableOut;
    logic           readEnableA, readEnableB, readEnableOut;
    logic           resetA, resetB, resetOut;
    logic [2*N-1:0] productIn;
    logic           overflowIn = 1'b0;
    logic           accessErrorA = 1'b0;
    logic           accessErrorB = 1'b0;
    logic           accessErrorOut = 1'b0;

    logic [8:0]     en_s;
    int             vectors = 0;
    int             miscompares = 0;
    int             cyc = 0;

    logic [N-1:0]   reg_a = '0;
    logic [N-1:0]   reg_b = '0;
    logic [2*N-1:0] reg_out = '0;

    multiplier_sequencer #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inReady(inReady), .a(a), .b(b),
        .outValid(outValid), .outReady(outReady),
        .result(result), .resultOverflow(resultOverflow), .resultError(resultError),
        .opA(opA), .opB(opB),
        .writeEnableA(writeEnableA), .writeEnableB(writeEnableB), .writeEnableOut(writeEnableOut),
        .readEnableA(readEnableA), .readEnableB(readEnableB), .readEnableOut(readEnableOut),
        .resetA(resetA), .resetB(resetB), .resetOut(resetOut),
        .productIn(productIn), .overflowIn(overflowIn),
        .accessErrorA(accessErrorA), .accessErrorB(accessErrorB), .accessErrorOut(accessErrorOut)
    );

    always #5 clk = ~clk;

    assign en_s = {writeEnableA, writeEnableB, writeEnableOut,
                   readEnableA, readEnableB, readEnableOut,
                   resetA, resetB, resetOut};

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural wrapper: input registers, combinational multiply, output register.
    always @(posedge clk) begin
        if (resetA) reg_a <= '0; else if (writeEnableA) reg_a <= opA;
        if (resetB) reg_b <= '0; else if (writeEnableB) reg_b <= opB;
        if (resetOut) reg_out <= '0;
        else if (writeEnableOut) reg_out <= {32'd0, reg_a} * {32'd0, reg_b};
    end
    assign productIn = reg_out;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Presents a pair and waits (bounded) for the accept edge; caller is at a negedge.
    task automatic accept(input logic [N-1:0] av, input logic [N-1:0] bv,
                          output bit ok, output int at_cyc);
        int k;
        k = 0;
        a = av;
        b = bv;
        inValid = 1'b1;
        while (inReady !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = (inReady === 1'b1);
        @(posedge clk);
        #1;
        at_cyc = cyc;
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (en_s !== EN_CLEAR) begin miscompares++; $display("FAIL reset_en: got %b want %b", en_s, EN_CLEAR); end
        vectors++; if (inReady !== 1'b0 || outValid !== 1'b0) begin miscompares++; $display("FAIL reset_hs: got inReady=%b outValid=%b want 0 0", inReady, outValid); end
        vectors++; if (result !== 64'd0 || opA !== 32'd0 || opB !== 32'd0) begin miscompares++; $display("FAIL reset_data: got result=%h opA=%h opB=%h want 0", result, opA, opB); end
        vectors++; if (resultOverflow !== 1'b0 || resultError !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got ovf=%b err=%b want 0 0", resultOverflow, resultError); end
        reset = 1'b0;
        #1;
        vectors++; if (en_s !== EN_CLEAR || inReady !== 1'b0) begin miscompares++; $display("FAIL clear_cycle: got en=%b inReady=%b want %b 0", en_s, inReady, EN_CLEAR); end
        @(negedge clk);
        vectors++; if (inReady !== 1'b1 || en_s !== EN_NONE) begin miscompares++; $display("FAIL idle_after_clear: got inReady=%b en=%b want 1 %b", inReady, en_s, EN_NONE); end
    endtask

    task automatic test_basic();
        bit ok;
        int t;
        overflowIn = 1'b1;
        accept(32'd3, 32'd5, ok, t);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_accept: got no accept want accept"); end
        @(negedge clk);
        vectors++; if (en_s !== EN_LOAD) begin miscompares++; $display("FAIL basic_load_en: got %b want %b", en_s, EN_LOAD); end
        vectors++; if (inReady !== 1'b0 || outValid !== 1'b0) begin miscompares++; $display("FAIL basic_load_hs: got inReady=%b outValid=%b want 0 0", inReady, outValid); end
        vectors++; if (opA !== 32'd3 || opB !== 32'd5) begin miscompares++; $display("FAIL basic_ops: got %h %h want 3 5", opA, opB); end
        @(negedge clk);
        vectors++; if (en_s !== EN_COMPUTE) begin miscompares++; $display("FAIL basic_compute_en: got %b want %b", en_s, EN_COMPUTE); end
        @(negedge clk);
        vectors++; if (en_s !== EN_DRAIN || outValid !== 1'b0) begin miscompares++; $display("FAIL basic_drain_en: got %b outValid=%b want %b 0", en_s, outValid, EN_DRAIN); end
        outReady = 1'b1;
        @(negedge clk);
        vectors++; if (outValid !== 1'b1 || en_s !== EN_NONE) begin miscompares++; $display("FAIL basic_valid: got outValid=%b en=%b want 1 %b", outValid, en_s, EN_NONE); end
        vectors++; if (result !== 64'd15) begin miscompares++; $display("FAIL basic_result: got %h want 15", result); end
        vectors++; if (resultOverflow !== 1'b1 || resultError !== 1'b0) begin miscompares++; $display("FAIL basic_flags: got ovf=%b err=%b want 1 0", resultOverflow, resultError); end
        overflowIn = 1'b0;
        @(negedge clk);
        vectors++; if (outValid !== 1'b0 || inReady !== 1'b1) begin miscompares++; $display("FAIL basic_release: got outValid=%b inReady=%b want 0 1", outValid, inReady); end
    endtask

    task automatic test_hold();
        bit ok;
        int t;
        outReady = 1'b0;
        accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, ok, t);
        vectors++; if (!ok) begin miscompares++; $display("FAIL hold_accept: got no accept want accept"); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++; if (outValid !== 1'b1 || inReady !== 1'b0) begin miscompares++; $display("FAIL hold_hs[%0d]: got outValid=%b inReady=%b want 1 0", i, outValid, inReady); end
            vectors++; if (result !== 64'hFFFF_FFFE_0000_0001) begin miscompares++; $display("FAIL hold_result[%0d]: got %h want fffffffe00000001", i, result); end
        end
        outReady = 1'b1;
        @(negedge clk);
        vectors++; if (outValid !== 1'b0 || inReady !== 1'b1) begin miscompares++; $display("FAIL hold_release: got outValid=%b inReady=%b want 0 1", outValid, inReady); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int t1, t2, k;
        outReady = 1'b1;
        accept(32'd7, 32'd9, ok1, t1);
        k = 0;
        @(negedge clk);
        while (outValid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        vectors++; if (outValid !== 1'b1 || result !== 64'd63) begin miscompares++; $display("FAIL b2b_first: got valid=%b result=%h want 1 3f", outValid, result); end
        accept(32'd2, 32'h8000_0000, ok2, t2);
        vectors++; if (!ok1 || !ok2 || (t2 - t1) != 5) begin miscompares++; $display("FAIL b2b_spacing: got %0d cycles want 5", t2 - t1); end
        k = 0;
        @(negedge clk);
        while (outValid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        vectors++; if (outValid !== 1'b1 || result !== 64'h1_0000_0000) begin miscompares++; $display("FAIL b2b_second: got valid=%b result=%h want 1 100000000", outValid, result); end
        @(negedge clk);
    endtask

    task automatic test_error();
        bit ok;
        int t;
        outReady = 1'b1;
        accept(32'd6, 32'd7, ok, t);
        repeat (2) @(negedge clk);
        @(negedge clk);
        accessErrorOut = 1'b1;
        @(negedge clk);
        accessErrorOut = 1'b0;
        vectors++; if (!ok || outValid !== 1'b1 || resultError !== 1'b1) begin miscompares++; $display("FAIL err_set: got valid=%b err=%b want 1 1", outValid, resultError); end
        vectors++; if (result !== 64'd42) begin miscompares++; $display("FAIL err_result: got %h want 2a", result); end
        @(negedge clk);
        accept(32'd1, 32'd1, ok, t);
        repeat (4) @(negedge clk);
        vectors++; if (!ok || outValid !== 1'b1 || resultError !== 1'b0 || result !== 64'd1) begin miscompares++; $display("FAIL err_clear: got valid=%b err=%b result=%h want 1 0 1", outValid, resultError, result); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit saw_valid;
        int t;
        outReady = 1'b1;
        accept(32'd4, 32'd4, ok, t);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (!ok || en_s !== EN_CLEAR || inReady !== 1'b0 || outValid !== 1'b0) begin miscompares++; $display("FAIL abort_outputs: got en=%b inReady=%b outValid=%b want %b 0 0", en_s, inReady, outValid, EN_CLEAR); end
        vectors++; if (opA !== 32'd0 || result !== 64'd0) begin miscompares++; $display("FAIL abort_data: got opA=%h result=%h want 0 0", opA, result); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (en_s !== EN_CLEAR || inReady !== 1'b0) begin miscompares++; $display("FAIL abort_clear: got en=%b inReady=%b want %b 0", en_s, inReady, EN_CLEAR); end
        saw_valid = 1'b0;
        @(negedge clk);
        vectors++; if (inReady !== 1'b1) begin miscompares++; $display("FAIL abort_idle: got inReady=%b want 1", inReady); end
        for (int i = 0; i < 6; i++) begin
            if (outValid === 1'b1) saw_valid = 1'b1;
            @(negedge clk);
        end
        vectors++; if (saw_valid) begin miscompares++; $display("FAIL abort_no_valid: got outValid seen want none"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_error();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiplier_sequencer.md
# multiplier_sequencer

Control stage directly upstream of the registered multiplier wrapper (input registers A/B, combinational multiplier, output register). It accepts operand pairs over a valid/ready handshake and drives the wrapper's write/read/reset enables in a fixed schedule. It captures the wrapper's product, overflow and access-error flags and presents one result per operation on a valid/ready output. It is the only agent driving the wrapper's enables; the wrapper is never left to software toggling.

## Interface
- N, 32, operand width; product is 2N.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- inValid  in  1  operand pair on a/b is valid.
- inReady  out  1  sequencer can accept a pair.
- a, b  in  N  operands.
- outValid  out  1  result fields valid.
- outReady  in  1  consumer takes result.
- result  out  2N  captured product.
- resultOverflow  out  1  captured wrapper overflow.
- resultError  out  1  any wrapper access error seen during this operation.
- opA, opB  out  N  data to wrapper a/b (held operand copy).
- writeEnableA, writeEnableB, writeEnableOut  out  1  wrapper write enables.
- readEnableA, readEnableB, readEnableOut  out  1  wrapper read enables.
- resetA, resetB, resetOut  out  1  wrapper register resets.
- productIn  in  2N  wrapper product.
- overflowIn  in  1  wrapper overflow.
- accessErrorA, accessErrorB, accessErrorOut  in  1  wrapper access errors.

## Operation
- States: CLEAR, IDLE, LOAD, COMPUTE, DRAIN, DONE.
- CLEAR: resetA/B/Out = 1 for exactly one cycle, inReady = 0; next IDLE.
- IDLE: inReady = 1; on inValid && inReady latch a/b into opA/opB holding regs; next LOAD.
- LOAD: writeEnableA = writeEnableB = 1, all read enables 0; next COMPUTE.
- COMPUTE: readEnableA = readEnableB = 1, writeEnableOut = 1; sample overflowIn into resultOverflow; next DRAIN.
- DRAIN: readEnableOut = 1, writeEnableOut = 0; sample productIn into result; next DONE.
- DONE: outValid = 1, result/resultOverflow/resultError stable; on outReady go IDLE, else hold.
- Never assert write and read enable of the same wrapper register in the same cycle.
- resultError: cleared on acceptance in IDLE; OR-accumulates accessErrorA|B|Out sampled in LOAD, COMPUTE, DRAIN. Error does not abort; the result is still delivered.
- opA/opB hold their value from acceptance until the next acceptance.
- No arithmetic in this block; result is a verbatim 2N-bit copy of productIn.

## Timing
- While reset is high, all outputs are 0 except resetA/B/Out = 1 (combinational from reset). State goes to CLEAR; opA/opB/result/flags are 0.
- First edge after reset deasserts: CLEAR cycle, then IDLE; inReady first high 1 cycle after reset release.
- Handshake at edge T (IDLE): LOAD T+1, COMPUTE T+2, DRAIN T+3, outValid high from T+4.
- Latency 4 cycles accept to outValid. Throughput 1 op per 5 cycles with outReady held high. inReady is low from T+1 until DONE exits.
- outValid && outReady at edge D: state IDLE at D+1, so inReady = 1 in that cycle. There is no same-cycle accept of a new pair in DONE.
- Reset asserted in any state: immediate abort, outputs as above, pending result lost, no outValid afterwards for that op.
- inValid dropping while inReady is low: ignored. Values on a/b outside the accept edge are don't-care.

## Test plan
- Reset release -> resetA/B/Out high one cycle, then inReady = 1; all other outputs 0.
- a=3, b=5, outReady=1 -> outValid 4 cycles after accept, result=15, resultOverflow=overflowIn as driven, resultError=0. Check enable sequence LOAD/COMPUTE/DRAIN exactly.
- a=b=0xFFFFFFFF -> result=0xFFFFFFFE00000001; outReady held low 10 cycles -> outValid and result stable, inReady 0 throughout.
- Back-to-back pairs (7,9),(2,0x80000000) with outReady=1 -> results 63 and 0x100000000, accepts 5 cycles apart.
- Force accessErrorOut=1 during DRAIN only -> resultError=1 for that op; next op resultError=0.
- Assert reset during COMPUTE -> outputs zero immediately, no outValid for that op, CLEAR cycle follows release.
